// File: rtl/dpram_arb_pkg.sv
// Shared types for the two-master DPRAM arbiter: FSM state encoding and read-owner tags.
package dpram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GNT0     = 3'd1,
    GNT1     = 3'd2,
    RD_BURST = 3'd3,
    WR_BURST = 3'd4
  } arb_state_t;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/dpram_arb_rdpipe.sv
// RD_LAT-stage {valid, owner} shift register that tracks issued RAM reads until their data returns.
module dpram_arb_rdpipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_valid_i,
  input  logic push_owner_i,
  output logic pop_valid_o,
  output logic pop_owner_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] owner_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      owner_q <= '0;
    end else begin
      valid_q[0] <= push_valid_i;
      owner_q[0] <= push_owner_i;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign pop_valid_o = valid_q[RD_LAT-1];
  assign pop_owner_o = owner_q[RD_LAT-1];

endmodule

// File: rtl/dpram_arbiter.sv
// Two-master Avalon-MM arbiter onto one DPRAM port; M0 bursts hold the grant.
// Define MEM_ARB_FIXED_PRIO_EN for fixed M0 priority instead of round-robin.
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 5,
  parameter int RD_LAT  = 2
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [ADDR_W-1:0] iM0_ADDRESS,
  input  logic              iM0_READ,
  input  logic              iM0_WRITE,
  input  logic [DATA_W-1:0] iM0_WRITE_DATA,
  input  logic [BURST_W-1:0] iM0_BURST_COUNT,
  output logic              oM0_WAIT_REQUEST,
  output logic [DATA_W-1:0] oM0_READ_DATA,
  output logic              oM0_READ_DATAVALID,
  input  logic [ADDR_W-1:0] iM1_ADDRESS,
  input  logic              iM1_READ,
  input  logic              iM1_WRITE,
  input  logic [DATA_W-1:0] iM1_WRITE_DATA,
  output logic              oM1_WAIT_REQUEST,
  output logic [DATA_W-1:0] oM1_READ_DATA,
  output logic              oM1_READ_DATAVALID,
  output logic              oRAM_CS,
  output logic              oRAM_WE,
  output logic [ADDR_W-1:0] oRAM_ADDRESS,
  output logic [DATA_W-1:0] oRAM_WRITE_DATA,
  input  logic [DATA_W-1:0] iRAM_READ_DATA,
  output logic [2:0]        oDBG_STATE
);

  // Handshake: a command/beat transfers in a cycle where (READ|WRITE) is high and WAIT_REQUEST
  // is low. WAIT_REQUEST depends only on arbiter state, never combinationally on the strobes.
  arb_state_t        state_q, state_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BURST_W-1:0] remain_q, remain_d;
  logic              ram_cs_q, ram_cs_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_own_q, ram_own_d;
  logic              req0, req1, m0_wins;
  logic [BURST_W-1:0] m0_len;
  logic              pipe_valid, pipe_owner;

  assign req0   = iM0_READ | iM0_WRITE;
  assign req1   = iM1_READ | iM1_WRITE;
  assign m0_len = (iM0_BURST_COUNT == '0) ? BURST_W'(1) : iM0_BURST_COUNT;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign m0_wins = 1'b1;
`else
  assign m0_wins = (last_q == OWN_M1);
`endif

  always_comb begin
    state_d          = state_q;
    last_d           = last_q;
    addr_d           = addr_q;
    remain_d         = remain_q;
    ram_cs_d         = 1'b0;
    ram_we_d         = 1'b0;
    ram_addr_d       = ram_addr_q;
    ram_wdata_d      = ram_wdata_q;
    ram_own_d        = ram_own_q;
    oM0_WAIT_REQUEST = 1'b1;
    oM1_WAIT_REQUEST = 1'b1;
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || m0_wins)) begin
          state_d = GNT0;
          last_d  = OWN_M0;
        end else if (req1) begin
          state_d = GNT1;
          last_d  = OWN_M1;
        end
      end
      GNT0: begin
        oM0_WAIT_REQUEST = 1'b0;
        state_d          = IDLE;
        if (req0) begin
          ram_cs_d    = 1'b1;
          ram_we_d    = iM0_WRITE;
          ram_addr_d  = iM0_ADDRESS;
          ram_own_d   = OWN_M0;
          addr_d      = iM0_ADDRESS + ADDR_W'(1);
          remain_d    = m0_len - BURST_W'(1);
          if (iM0_WRITE) ram_wdata_d = iM0_WRITE_DATA;
          if (m0_len != BURST_W'(1)) state_d = iM0_WRITE ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST: begin
        ram_cs_d   = 1'b1;
        ram_addr_d = addr_q;
        ram_own_d  = OWN_M0;
        addr_d     = addr_q + ADDR_W'(1);
        remain_d   = remain_q - BURST_W'(1);
        if (remain_q == BURST_W'(1)) state_d = IDLE;
      end
      WR_BURST: begin
        oM0_WAIT_REQUEST = 1'b0;
        if (iM0_WRITE) begin
          ram_cs_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = addr_q;
          ram_wdata_d = iM0_WRITE_DATA;
          ram_own_d   = OWN_M0;
          addr_d      = addr_q + ADDR_W'(1);
          remain_d    = remain_q - BURST_W'(1);
          if (remain_q == BURST_W'(1)) state_d = IDLE;
        end
      end
      GNT1: begin
        oM1_WAIT_REQUEST = 1'b0;
        state_d          = IDLE;
        if (req1) begin
          ram_cs_d   = 1'b1;
          ram_we_d   = iM1_WRITE;
          ram_addr_d = iM1_ADDRESS;
          ram_own_d  = OWN_M1;
          if (iM1_WRITE) ram_wdata_d = iM1_WRITE_DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q     <= IDLE;
      last_q      <= OWN_M1;
      addr_q      <= '0;
      remain_q    <= '0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_own_q   <= OWN_M0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_own_q   <= ram_own_d;
    end
  end

  // Tags enter the pipe from the registered strobe, so the last stage lines up with RAM data.
  dpram_arb_rdpipe #(.RD_LAT(RD_LAT)) u_rdpipe (
    .clk_i       (iCLK),
    .rst_i       (iRESET),
    .push_valid_i(ram_cs_q & ~ram_we_q),
    .push_owner_i(ram_own_q),
    .pop_valid_o (pipe_valid),
    .pop_owner_o (pipe_owner)
  );

  assign oM0_READ_DATAVALID = pipe_valid & (pipe_owner == OWN_M0);
  assign oM1_READ_DATAVALID = pipe_valid & (pipe_owner == OWN_M1);
  assign oM0_READ_DATA      = oM0_READ_DATAVALID ? iRAM_READ_DATA : '0;
  assign oM1_READ_DATA      = oM1_READ_DATAVALID ? iRAM_READ_DATA : '0;
  assign oRAM_CS            = ram_cs_q;
  assign oRAM_WE            = ram_we_q;
  assign oRAM_ADDRESS       = ram_addr_q;
  assign oRAM_WRITE_DATA    = ram_wdata_q;
  assign oDBG_STATE         = state_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: RAM model, reference memory + expected queues, directed and random traffic.
module tb_dpram_arbiter;
  import dpram_arb_pkg::*;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int BURST_W = 5;
  localparam int RD_LAT  = 2;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int RW      = 1 + ADDR_W + DATA_W;

  logic               iCLK = 1'b0;
  logic               iRESET;
  logic [ADDR_W-1:0]  iM0_ADDRESS, iM1_ADDRESS;
  logic               iM0_READ, iM0_WRITE, iM1_READ, iM1_WRITE;
  logic [DATA_W-1:0]  iM0_WRITE_DATA, iM1_WRITE_DATA;
  logic [BURST_W-1:0] iM0_BURST_COUNT;
  logic               oM0_WAIT_REQUEST, oM1_WAIT_REQUEST;
  logic [DATA_W-1:0]  oM0_READ_DATA, oM1_READ_DATA;
  logic               oM0_READ_DATAVALID, oM1_READ_DATAVALID;
  logic               oRAM_CS, oRAM_WE;
  logic [ADDR_W-1:0]  oRAM_ADDRESS;
  logic [DATA_W-1:0]  oRAM_WRITE_DATA, iRAM_READ_DATA;
  logic [2:0]         oDBG_STATE;

  dpram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .RD_LAT(RD_LAT)) dut (
    .iCLK(iCLK), .iRESET(iRESET),
    .iM0_ADDRESS(iM0_ADDRESS), .iM0_READ(iM0_READ), .iM0_WRITE(iM0_WRITE),
    .iM0_WRITE_DATA(iM0_WRITE_DATA), .iM0_BURST_COUNT(iM0_BURST_COUNT),
    .oM0_WAIT_REQUEST(oM0_WAIT_REQUEST), .oM0_READ_DATA(oM0_READ_DATA),
    .oM0_READ_DATAVALID(oM0_READ_DATAVALID),
    .iM1_ADDRESS(iM1_ADDRESS), .iM1_READ(iM1_READ), .iM1_WRITE(iM1_WRITE),
    .iM1_WRITE_DATA(iM1_WRITE_DATA), .oM1_WAIT_REQUEST(oM1_WAIT_REQUEST),
    .oM1_READ_DATA(oM1_READ_DATA), .oM1_READ_DATAVALID(oM1_READ_DATAVALID),
    .oRAM_CS(oRAM_CS), .oRAM_WE(oRAM_WE), .oRAM_ADDRESS(oRAM_ADDRESS),
    .oRAM_WRITE_DATA(oRAM_WRITE_DATA), .iRAM_READ_DATA(iRAM_READ_DATA),
    .oDBG_STATE(oDBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at time %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- RAM model ----------------
  logic [DATA_W-1:0] ram_mem  [DEPTH];
  logic [DATA_W-1:0] ram_pipe [RD_LAT];
  always @(posedge iCLK) begin
    for (int i = RD_LAT - 1; i > 0; i--) ram_pipe[i] = ram_pipe[i-1];
    ram_pipe[0] = (oRAM_CS && !oRAM_WE) ? ram_mem[oRAM_ADDRESS] : 32'hDEAD_BEEF;
    if (oRAM_CS && oRAM_WE) ram_mem[oRAM_ADDRESS] = oRAM_WRITE_DATA;
  end
  assign iRAM_READ_DATA = ram_pipe[RD_LAT-1];

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [RW-1:0]     ram_exp_q[$];
  logic [DATA_W-1:0] exp_q0[$], exp_q1[$];
  int                cyc_q0[$], cyc_q1[$];
  int                grant_log[$];
  int                n_cmp = 0, n_bad = 0, v1_cnt = 0;
  logic [RW-1:0]     e_ram;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge iCLK) begin
    if (!iRESET) begin
      check("dual_grant", {63'd0, !oM0_WAIT_REQUEST && !oM1_WAIT_REQUEST}, 64'd0);
      if (oRAM_CS) begin
        if (ram_exp_q.size() == 0) check("ram_unexpected_cs", {63'd0, oRAM_CS}, 64'd0);
        else begin
          e_ram = ram_exp_q.pop_front();
          check("ram_access", {oRAM_WE, oRAM_ADDRESS, oRAM_WE ? oRAM_WRITE_DATA : {DATA_W{1'b0}}}, e_ram);
        end
      end
      if (oM0_READ_DATAVALID) begin
        if (exp_q0.size() == 0) check("m0_spurious_valid", {63'd0, oM0_READ_DATAVALID}, 64'd0);
        else begin
          check("m0_rdata", oM0_READ_DATA, exp_q0.pop_front());
          check("m0_rd_cycle", cyc, cyc_q0.pop_front());
        end
      end
      if (oM1_READ_DATAVALID) begin
        v1_cnt++;
        if (exp_q1.size() == 0) check("m1_spurious_valid", {63'd0, oM1_READ_DATAVALID}, 64'd0);
        else begin
          check("m1_rdata", oM1_READ_DATA, exp_q1.pop_front());
          check("m1_rd_cycle", cyc, cyc_q1.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic m1_op(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       output int acc);
    int n = 0;
    acc = -1;
    iM1_ADDRESS = a; iM1_WRITE_DATA = d; iM1_WRITE = wr; iM1_READ = !wr;
    @(negedge iCLK);
    while (oM1_WAIT_REQUEST && n < 300) begin n++; @(negedge iCLK); end
    if (oM1_WAIT_REQUEST) check("m1_accept_timeout", {63'd0, oM1_WAIT_REQUEST}, 64'd0);
    else begin
      acc = cyc;
      grant_log.push_back(1);
      if (wr) begin
        ram_exp_q.push_back({1'b1, a, d});
        ref_mem[a] = d;
      end else begin
        ram_exp_q.push_back({1'b0, a, {DATA_W{1'b0}}});
        exp_q1.push_back(ref_mem[a]);
        cyc_q1.push_back(cyc + 1 + RD_LAT);
      end
    end
    @(posedge iCLK); #1;
    iM1_READ = 1'b0; iM1_WRITE = 1'b0;
  endtask

  task automatic m0_read(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc, output int acc);
    int n = 0;
    int len;
    logic [ADDR_W-1:0] ak;
    acc = -1;
    iM0_ADDRESS = a; iM0_BURST_COUNT = bc; iM0_READ = 1'b1; iM0_WRITE = 1'b0;
    @(negedge iCLK);
    while (oM0_WAIT_REQUEST && n < 300) begin n++; @(negedge iCLK); end
    if (oM0_WAIT_REQUEST) check("m0_rd_accept_timeout", {63'd0, oM0_WAIT_REQUEST}, 64'd0);
    else begin
      acc = cyc;
      grant_log.push_back(0);
      len = (bc == 0) ? 1 : int'(bc);
      for (int k = 0; k < len; k++) begin
        ak = a + ADDR_W'(k);
        ram_exp_q.push_back({1'b0, ak, {DATA_W{1'b0}}});
        exp_q0.push_back(ref_mem[ak]);
        cyc_q0.push_back(cyc + 1 + RD_LAT + k);
      end
    end
    @(posedge iCLK); #1;
    iM0_READ = 1'b0; iM0_BURST_COUNT = '0;
  endtask

  task automatic m0_write(input logic [ADDR_W-1:0] a, input logic [BURST_W-1:0] bc, input int gap,
                          input logic [DATA_W-1:0] d0, output int acc_first, output int acc_last);
    int n;
    int len;
    bit ok = 1'b1;
    logic [ADDR_W-1:0] ak;
    logic [DATA_W-1:0] dk;
    len = (bc == 0) ? 1 : int'(bc);
    acc_first = -1; acc_last = -1;
    iM0_ADDRESS = a; iM0_BURST_COUNT = bc;
    for (int k = 0; k < len && ok; k++) begin
      ak = a + ADDR_W'(k);
      dk = d0 + DATA_W'(k);
      iM0_WRITE = 1'b1; iM0_WRITE_DATA = dk;
      n = 0;
      @(negedge iCLK);
      while (oM0_WAIT_REQUEST && n < 300) begin n++; @(negedge iCLK); end
      if (oM0_WAIT_REQUEST) begin
        check("m0_wr_accept_timeout", {63'd0, oM0_WAIT_REQUEST}, 64'd0);
        ok = 1'b0;
      end else begin
        if (k == 0) begin acc_first = cyc; grant_log.push_back(0); end
        acc_last = cyc;
        ram_exp_q.push_back({1'b1, ak, dk});
        ref_mem[ak] = dk;
      end
      @(posedge iCLK); #1;
      iM0_WRITE = 1'b0;
      if (k != len - 1) repeat (gap) begin @(posedge iCLK); #1; end
    end
    iM0_BURST_COUNT = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((ram_exp_q.size() + exp_q0.size() + exp_q1.size()) != 0 && n < 300) begin
      @(posedge iCLK); n++;
    end
    check("drain_pending", ram_exp_q.size() + exp_q0.size() + exp_q1.size(), 64'd0);
    repeat (RD_LAT + 2) @(posedge iCLK);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return ADDR_W'(DEPTH - 4 + $urandom_range(0, 3));
    return ADDR_W'($urandom_range(0, DEPTH - 1));
  endfunction

  // ---------------- stimulus ----------------
  int a0, a1, a2, a3, first;
  logic [DATA_W-1:0] v;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    for (int i = 0; i < RD_LAT; i++) ram_pipe[i] = '0;
    ram_mem[12'h010] = 32'hCAFE_0001;
    ref_mem[12'h010] = 32'hCAFE_0001;
    iRESET = 1'b1;
    iM0_ADDRESS = '0; iM0_READ = 0; iM0_WRITE = 0; iM0_WRITE_DATA = '0; iM0_BURST_COUNT = '0;
    iM1_ADDRESS = '0; iM1_READ = 0; iM1_WRITE = 0; iM1_WRITE_DATA = '0;

    // reset state
    @(negedge iCLK);
    check("rst_m0_wait", oM0_WAIT_REQUEST, 1);
    check("rst_m1_wait", oM1_WAIT_REQUEST, 1);
    check("rst_m0_valid", oM0_READ_DATAVALID, 0);
    check("rst_m1_valid", oM1_READ_DATAVALID, 0);
    check("rst_m0_rdata", oM0_READ_DATA, 0);
    check("rst_ram_cs", oRAM_CS, 0);
    check("rst_ram_we", oRAM_WE, 0);
    check("rst_ram_addr", oRAM_ADDRESS, 0);
    check("rst_ram_wdata", oRAM_WRITE_DATA, 0);
    check("rst_state", oDBG_STATE, IDLE);
    repeat (2) @(posedge iCLK);
    #1 iRESET = 1'b0;
    @(posedge iCLK); #1;

    // 1: single M1 read, latency checked by the scoreboard
    m1_op(1'b0, 12'h010, '0, a0);
    drain();
    check("t1_m1_valid_count", v1_cnt, 1);

    // 2: wrapping write burst, then read it back as a burst
    m0_write(12'hFFE, 5'd4, 0, 32'd1, a0, a1);
    m0_read(12'hFFE, 5'd4, a0);
    drain();

    // 3: read burst 8 with M1 contending
    fork
      m0_read(12'h100, 5'd8, a0);
      begin @(posedge iCLK); #1; m1_op(1'b0, 12'h200, '0, a1); end
    join
    drain();
    check("t3_m1_after_burst", a1 - a0, 9);

    // 4: both masters requesting continuously
    first = 1 - grant_log[grant_log.size() - 1];
    grant_log.delete();
    fork
      for (int i = 0; i < 6; i++) m0_read(rand_addr(), 5'd1, a2);
      for (int i = 0; i < 6; i++) m1_op(1'($urandom_range(0, 1)), rand_addr(), $urandom, a3);
    join
    drain();
    check("t4_grant_count", grant_log.size(), 12);
    for (int i = 0; i < 12 && i < grant_log.size(); i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      check("t4_grant_order", grant_log[i], (i < 6) ? 0 : 1);
`else
      check("t4_grant_order", grant_log[i], (first + i) % 2);
`endif
    end

    // 5: write burst with idle gaps; M1 starved until the last beat
    fork
      m0_write(12'h300, 5'd3, 5, $urandom, a0, a1);
      begin @(posedge iCLK); #1; m1_op(1'b1, 12'h301, 32'h5555_AAAA, a2); end
    join
    drain();
    check("t5_beat_spacing", a1 - a0, 12);
    check("t5_m1_after_wr_burst", a2 - a1, 2);

    // 6: reset in the middle of a read burst
    m0_read(12'h400, 5'd8, a0);
    repeat (3) begin @(posedge iCLK); #1; end
    iRESET = 1'b1;
    ram_exp_q.delete(); exp_q0.delete(); cyc_q0.delete();
    @(negedge iCLK);
    check("t6_rst_m0_wait", oM0_WAIT_REQUEST, 1);
    check("t6_rst_m1_wait", oM1_WAIT_REQUEST, 1);
    check("t6_rst_valid", oM0_READ_DATAVALID | oM1_READ_DATAVALID, 0);
    check("t6_rst_cs", oRAM_CS, 0);
    check("t6_rst_state", oDBG_STATE, IDLE);
    @(posedge iCLK); #1;
    iRESET = 1'b0;
    repeat (RD_LAT + 3) begin
      @(negedge iCLK);
      check("t6_no_valid_after_rst", oM0_READ_DATAVALID | oM1_READ_DATAVALID, 0);
    end
    @(posedge iCLK); #1;
    grant_log.delete();
    fork
      m0_read(12'h500, 5'd1, a0);
      m1_op(1'b0, 12'h501, '0, a1);
    join
    check("t6_ptr_first", grant_log[0], 0);
    check("t6_ptr_second", grant_log[1], 1);
    m0_read(12'h600, 5'd8, a0);
    drain();

    // random mixed traffic
    fork
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 1) == 1)
          m0_read(rand_addr(), 5'($urandom_range(0, 7)), a2);
        else
          m0_write(rand_addr(), 5'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom, a2, a3);
        repeat ($urandom_range(0, 2)) begin @(posedge iCLK); #1; end
      end
      for (int i = 0; i < 25; i++) begin
        m1_op(1'($urandom_range(0, 1)), rand_addr(), $urandom, a1);
        repeat ($urandom_range(0, 3)) begin @(posedge iCLK); #1; end
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
